// File: rtl/exec_stage_mc.sv
// Execute stage: single-cycle ALU and address generation, an iterative
// shift-add multiplier, and an output register that holds under backpressure.
module exec_stage_mc #(
  parameter int XLEN       = 32,
  parameter int MUL_STEP   = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_src1,
  input  logic [XLEN-1:0]       in_src2,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [2:0]            in_func3,
  input  logic [6:0]            in_func7,
  input  logic                  in_is_r,
  input  logic                  in_is_i,
  input  logic                  in_is_mul,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [REG_ADDR_W-1:0] in_dst_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [REG_ADDR_W-1:0] out_dst_reg,
  output logic                  out_is_load,
  output logic                  out_is_store,
  output logic                  out_reg_data_ready,
  output logic                  out_illegal,
  output logic                  busy
);

  localparam int MUL_ITERS = XLEN / MUL_STEP;
  localparam int CNT_W     = $clog2(MUL_ITERS + 1);
  localparam int SHW       = $clog2(XLEN);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                state, state_next;
  logic                  out_free, accept, is_mem, mul_start, mul_done;
  logic [XLEN-1:0]       op2, alu_res, single_res;
  logic [SHW-1:0]        shamt;
  logic                  single_illegal, single_rdr;
  logic                  neg1, neg2;
  logic [XLEN-1:0]       mag1, mag2;
  logic [2*XLEN-1:0]     mcand_sh, acc, pp, acc_next, mul_fin, mul_signed;
  logic [XLEN-1:0]       mplier;
  logic [CNT_W-1:0]      cnt;
  logic                  mul_neg, mul_hi, last_iter, saturated;
  logic [REG_ADDR_W-1:0] mul_dst;
  logic                  unused_func7;

  assign unused_func7 = ^{in_func7[6], in_func7[4:0]};

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == S_IDLE) && out_free && !flush;
  assign accept    = in_valid && in_ready;
  assign is_mem    = in_is_load || in_is_store;
  assign mul_start = accept && in_is_mul && !is_mem && !in_func3[2];
  assign busy      = (state == S_MUL);

  assign op2   = (in_is_i || is_mem) ? in_imm : in_src2;
  assign shamt = op2[SHW-1:0];

  // Single-cycle integer ALU selected by funct3.
  always_comb begin
    alu_res = '0;
    case (in_func3)
      3'b000: begin
        if (in_is_r && in_func7[5]) alu_res = in_src1 - op2;
        else                        alu_res = in_src1 + op2;
      end
      3'b001: alu_res = in_src1 << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(in_src1) < $signed(op2))};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, (in_src1 < op2)};
      3'b100: alu_res = in_src1 ^ op2;
      3'b101: begin
        if (in_func7[5]) alu_res = $signed(in_src1) >>> shamt;
        else             alu_res = in_src1 >> shamt;
      end
      3'b110: alu_res = in_src1 | op2;
      default: alu_res = in_src1 & op2;
    endcase
  end

  // Result and flags for anything that completes in one cycle.
  always_comb begin
    single_illegal = in_is_mul && !is_mem && in_func3[2];
    if (is_mem)              single_res = in_src1 + in_imm;
    else if (single_illegal) single_res = '0;
    else                     single_res = alu_res;
    single_rdr = (in_is_r || in_is_i || in_is_mul) && !is_mem && !single_illegal;
  end

  // Operand magnitudes; the product sign is reapplied at completion.
  always_comb begin
    neg1 = (in_func3[1:0] != 2'b11) && in_src1[XLEN-1];
    neg2 = !in_func3[1] && in_src2[XLEN-1];
    mag1 = neg1 ? (~in_src1 + 1'b1) : in_src1;
    mag2 = neg2 ? (~in_src2 + 1'b1) : in_src2;
  end

  // Partial products for the MUL_STEP multiplier bits retired this cycle.
  always_comb begin
    pp = '0;
    for (int unsigned k = 0; k < MUL_STEP; k++) begin
      if (mplier[k]) pp = pp + (mcand_sh << k);
    end
    acc_next   = acc + pp;
    last_iter  = (state == S_MUL) && (cnt == CNT_W'(MUL_ITERS - 1));
    saturated  = (state == S_MUL) && (cnt == CNT_W'(MUL_ITERS));
    // A result parked while the output was busy is already in acc.
    mul_fin    = saturated ? acc : acc_next;
    mul_signed = mul_neg ? (~mul_fin + 1'b1) : mul_fin;
    mul_done   = (last_iter || saturated) && out_free && !flush;
  end

  // Multiplier FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Multiplier FSM next state: flush wins over completion.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (mul_start) state_next = S_MUL;
      S_MUL:   if (flush || mul_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Multiplier datapath: shift-add, counter saturates at MUL_ITERS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_sh <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      mul_neg  <= 1'b0;
      mul_hi   <= 1'b0;
      mul_dst  <= '0;
    end else if (mul_start) begin
      mcand_sh <= {{XLEN{1'b0}}, mag1};
      mplier   <= mag2;
      acc      <= '0;
      cnt      <= '0;
      mul_neg  <= neg1 ^ neg2;
      mul_hi   <= (in_func3[1:0] != 2'b00);
      mul_dst  <= in_dst_reg;
    end else if ((state == S_MUL) && !saturated) begin
      mcand_sh <= mcand_sh << MUL_STEP;
      mplier   <= mplier >> MUL_STEP;
      acc      <= acc_next;
      cnt      <= cnt + 1'b1;
    end
  end

  // Output register: load, hold under backpressure, clear on handshake/flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid          <= 1'b0;
      out_result         <= '0;
      out_dst_reg        <= '0;
      out_is_load        <= 1'b0;
      out_is_store       <= 1'b0;
      out_reg_data_ready <= 1'b0;
      out_illegal        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid          <= 1'b1;
      out_result         <= single_res;
      out_dst_reg        <= in_dst_reg;
      out_is_load        <= in_is_load;
      out_is_store       <= in_is_store;
      out_reg_data_ready <= single_rdr;
      out_illegal        <= single_illegal;
    end else if (mul_done) begin
      out_valid          <= 1'b1;
      out_result         <= mul_hi ? mul_signed[2*XLEN-1:XLEN] : mul_signed[XLEN-1:0];
      out_dst_reg        <= mul_dst;
      out_is_load        <= 1'b0;
      out_is_store       <= 1'b0;
      out_reg_data_ready <= 1'b1;
      out_illegal        <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Testbench for exec_stage_mc: directed literal cases plus randomized traffic
// against a cycle-level behavioural model.
module tb_exec_stage_mc;

  localparam int XLEN  = 32;
  localparam int STEP  = 4;
  localparam int RW    = 5;
  localparam int ITERS = XLEN / STEP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, busy;
  logic [31:0]   in_src1 = '0, in_src2 = '0, in_imm = '0;
  logic [2:0]    in_func3 = '0;
  logic [6:0]    in_func7 = '0;
  logic          in_is_r = 1'b0, in_is_i = 1'b0, in_is_mul = 1'b0;
  logic          in_is_load = 1'b0, in_is_store = 1'b0;
  logic [RW-1:0] in_dst_reg = '0;
  logic [31:0]   out_result;
  logic [RW-1:0] out_dst_reg;
  logic          out_is_load, out_is_store, out_reg_data_ready, out_illegal;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  exec_stage_mc #(.XLEN(XLEN), .MUL_STEP(STEP), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_func3(in_func3), .in_func7(in_func7),
    .in_is_r(in_is_r), .in_is_i(in_is_i), .in_is_mul(in_is_mul),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_dst_reg(in_dst_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dst_reg(out_dst_reg),
    .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_reg_data_ready(out_reg_data_ready), .out_illegal(out_illegal),
    .busy(busy)
  );

  typedef struct {
    logic [31:0]   res;
    logic [RW-1:0] dst;
    logic          ld, st, rdr, ill;
  } res_t;

  // Model state: visible output, cycles left on the multiplier, parked product.
  bit   m_valid;
  int   m_left;
  res_t m_out, m_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of the instruction currently on the input ports.
  function automatic res_t calc();
    res_t        r;
    logic [31:0] b2;
    logic [4:0]  sh;
    logic        mem;
    longint      a, b;
    logic [63:0] p;
    mem   = in_is_load || in_is_store;
    b2    = (in_is_i || mem) ? in_imm : in_src2;
    sh    = b2[4:0];
    r.dst = in_dst_reg;
    r.ld  = in_is_load;
    r.st  = in_is_store;
    r.ill = 1'b0;
    r.res = '0;
    if (mem) r.res = in_src1 + in_imm;
    else if (in_is_mul && in_func3[2]) r.ill = 1'b1;
    else if (in_is_mul) begin
      a = (in_func3[1:0] == 2'b11) ? longint'({32'h0, in_src1}) : longint'($signed(in_src1));
      b = in_func3[1] ? longint'({32'h0, in_src2}) : longint'($signed(in_src2));
      p = a * b;
      r.res = (in_func3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    end else begin
      case (in_func3)
        3'd0: begin
          if (in_is_r && in_func7[5]) r.res = in_src1 - b2;
          else                        r.res = in_src1 + b2;
        end
        3'd1: r.res = in_src1 << sh;
        3'd2: r.res = ($signed(in_src1) < $signed(b2)) ? 32'd1 : 32'd0;
        3'd3: r.res = (in_src1 < b2) ? 32'd1 : 32'd0;
        3'd4: r.res = in_src1 ^ b2;
        3'd5: begin
          if (in_func7[5]) r.res = $signed(in_src1) >>> sh;
          else             r.res = in_src1 >> sh;
        end
        3'd6: r.res = in_src1 | b2;
        default: r.res = in_src1 & b2;
      endcase
    end
    r.rdr = (in_is_r || in_is_i || in_is_mul) && !mem && !r.ill;
    return r;
  endfunction

  // Behavioural model advanced on each clock edge.
  always @(posedge clk or negedge rst_n) begin
    bit   free, rdy, loaded;
    res_t r;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_left  = 0;
    end else begin
      free   = !m_valid || out_ready;
      rdy    = (m_left == 0) && free && !flush;
      loaded = 1'b0;
      if (flush) begin
        m_valid = 1'b0;
        m_left  = 0;
      end else begin
        if (m_left > 1) m_left--;
        else if (m_left == 1) begin
          if (free) begin
            m_out  = m_pend;
            m_left = 0;
            loaded = 1'b1;
          end
        end else if (in_valid && rdy) begin
          r = calc();
          if (in_is_mul && !in_is_load && !in_is_store && !in_func3[2]) begin
            m_pend = r;
            m_left = ITERS;
          end else begin
            m_out  = r;
            loaded = 1'b1;
          end
        end
        if (loaded) m_valid = 1'b1;
        else if (m_valid && out_ready) m_valid = 1'b0;
      end
    end
  end

  // Compare DUT against the model every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, m_valid);
      chk("busy", busy, m_left != 0);
      chk("in_ready", in_ready, (m_left == 0) && (!m_valid || out_ready) && !flush);
      if (m_valid) begin
        chk("out_result", out_result, m_out.res);
        chk("out_dst_reg", out_dst_reg, m_out.dst);
        chk("out_is_load", out_is_load, m_out.ld);
        chk("out_is_store", out_is_store, m_out.st);
        chk("out_reg_data_ready", out_reg_data_ready, m_out.rdr);
        chk("out_illegal", out_illegal, m_out.ill);
      end
    end
  end

  task automatic set_op(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic r, input logic i, input logic m,
                        input logic ld, input logic st);
    in_src1 = s1; in_src2 = s2; in_imm = imm;
    in_func3 = f3; in_func7 = f7;
    in_is_r = r; in_is_i = i; in_is_mul = m;
    in_is_load = ld; in_is_store = st;
    in_dst_reg = RW'($urandom_range(1, 31));
  endtask

  // Present the op for one edge, then wait (bounded) for its result.
  task automatic issue_check(input string name, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    chk({name, " result"}, out_result, exp_res);
    chk({name, " latency"}, lat, exp_lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic rand_inputs();
    flush     = ($urandom_range(0, 99) < 3);
    out_ready = ($urandom_range(0, 99) < 70);
    in_valid  = ($urandom_range(0, 99) < 70);
    set_op(pick(), pick(), pick(), 3'($urandom), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom),
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    case ($urandom_range(0, 5))
      0: in_is_r = 1'b1;
      1: in_is_i = 1'b1;
      2: begin in_is_load = 1'b1; in_is_i = 1'b1; end
      3: in_is_store = 1'b1;
      default: begin in_is_r = 1'b1; in_is_mul = 1'b1; in_func7 = 7'h01; end
    endcase
  endtask

  initial begin
    bit seen;
    logic [31:0] held;
    #1 rst_n = 1'b0;
    #2;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_result", out_result, 32'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset flags", {out_dst_reg, out_is_load, out_is_store, out_reg_data_ready, out_illegal}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Directed cases with hand-computed results.
    @(posedge clk); #1;
    set_op(32'd5, 32'h1234, 32'hFFFF_FFFD, 3'b000, 7'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue_check("ADDI", 32'h0000_0002, 0);
    chk("ADDI rdr", out_reg_data_ready, 1'b1);
    @(posedge clk); #1;
    set_op(32'd3, 32'd5, 32'h0, 3'b000, 7'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_check("SUB", 32'hFFFF_FFFE, 0);
    @(posedge clk); #1;
    set_op(32'h8000_0000, 32'd4, 32'h0, 3'b101, 7'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_check("SRA", 32'hF800_0000, 0);
    @(posedge clk); #1;
    set_op(32'h8000_0000, 32'd4, 32'h0, 3'b101, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_check("SRL", 32'h0800_0000, 0);
    @(posedge clk); #1;
    set_op(32'd1, 32'hFFFF_FFFF, 32'h0, 3'b011, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_check("SLTU", 32'h1, 0);
    @(posedge clk); #1;
    set_op(32'd1, 32'hFFFF_FFFF, 32'h0, 3'b010, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_check("SLT", 32'h0, 0);
    @(posedge clk); #1;
    set_op(32'hFFFF_FFFE, 32'd3, 32'h0, 3'b001, 7'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_check("MULH", 32'hFFFF_FFFF, ITERS);
    @(posedge clk); #1;
    set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3'b011, 7'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_check("MULHU", 32'hFFFF_FFFE, ITERS);
    @(posedge clk); #1;
    set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3'b000, 7'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_check("MUL", 32'h0000_0001, ITERS);
    @(posedge clk); #1;
    set_op(32'h1000, 32'h55, 32'hFFFF_FFFC, 3'b010, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue_check("LW", 32'h0000_0FFC, 0);
    chk("LW is_load", out_is_load, 1'b1);
    chk("LW rdr", out_reg_data_ready, 1'b0);
    @(posedge clk); #1;
    set_op(32'd100, 32'd7, 32'h0, 3'b100, 7'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_check("DIV", 32'h0, 0);
    chk("DIV illegal", out_illegal, 1'b1);
    chk("DIV rdr", out_reg_data_ready, 1'b0);

    // Backpressure: hold a result for three cycles with a second op queued.
    @(posedge clk); #1;
    set_op(32'd10, 32'd20, 32'h0, 3'b000, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_op(32'd7, 32'd8, 32'h0, 3'b000, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp hold valid", out_valid, 1'b1);
      chk("bp hold result", out_result, 32'd30);
      chk("bp in_ready", in_ready, 1'b0);
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp next valid", out_valid, 1'b1);
    chk("bp next result", out_result, 32'd15);

    // Flush on the fourth multiply cycle.
    @(posedge clk); #1;
    set_op(32'd6, 32'd7, 32'h0, 3'b000, 7'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush busy", busy, 1'b0);
    chk("flush in_ready", in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush no result", seen, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk); #1;
    set_op(32'd9, 32'd9, 32'h0, 3'b000, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_op(32'd123, 32'd45, 32'h0, 3'b000, 7'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    held = out_result;
    chk("pre-reset result", held, 32'd18);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", out_valid, 1'b0);
    chk("async rst result", out_result, 32'h0);
    chk("async rst busy", busy, 1'b0);
    chk("async rst flags", {out_dst_reg, out_is_load, out_is_store, out_reg_data_ready, out_illegal}, '0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      rand_inputs();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
- Parametrised, handshaked execute stage for the RV32IM/RV64IM core pipeline; sits between decode/register-read and memory stage.
- Single-cycle ALU ops (RV I-class), address generation for load/store, iterative multi-cycle multiplier (MUL/MULH/MULHSU/MULHU).
- Registered output held under downstream backpressure.
- Synchronous flush for branch/exception squash.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- MUL_STEP, 4, multiplier bits retired per cycle; must divide XLEN; MUL_ITERS = XLEN/MUL_STEP.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of in-flight and held instruction.
- in_valid  in  1  decode presents instruction.
- in_ready  out  1  stage can accept this cycle.
- in_src1  in  XLEN  rs1 data.
- in_src2  in  XLEN  rs2 data.
- in_imm  in  XLEN  sign-extended immediate.
- in_func3  in  3  funct3.
- in_func7  in  7  funct7.
- in_is_r / in_is_i / in_is_mul / in_is_load / in_is_store  in  1 each  class flags.
- in_dst_reg  in  REG_ADDR_W  rd index.
- out_valid  out  1  result register valid.
- out_ready  in  1  downstream accepts.
- out_result  out  XLEN  ALU/mul result or memory address.
- out_dst_reg  out  REG_ADDR_W  rd index.
- out_is_load / out_is_store  out  1 each  passed through.
- out_reg_data_ready  out  1  result is rd writeback data.
- out_illegal  out  1  unsupported op (M-ext divide).
- busy  out  1  multiplier FSM not IDLE.

Behaviour:
- Reset (rst=0, async): FSM=IDLE; out_valid, out_result, out_dst_reg, all out flags, busy = 0. In-flight multiply discarded.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Accept = in_valid && in_ready.
- Operands: op1 = in_src1; op2 = in_imm if (is_i || is_load || is_store) else in_src2.
- Load/store: result = op1 + in_imm (wrap mod 2^XLEN); out_reg_data_ready=0.
- ALU (is_r/is_i, !is_mul), by func3:
  - 000: ADD, or SUB when is_r && func7[5].
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when func7[5].
  - 110: OR.
  - 111: AND.
  - Shift amount = op2[log2(XLEN)-1:0]. SLT/SLTU result zero-extended 0/1.
- Single-cycle latency: accepted at edge N -> out_valid=1 after edge N, result registered.
- is_mul, func3[2]=0:
  - FSM IDLE->MUL on accept; latch |src1|, |src2| magnitudes per signedness.
  - Signedness: MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned.
  - Each cycle adds MUL_STEP partial products into a 2*XLEN accumulator.
  - After MUL_ITERS cycles: negate if signs differ, select low half (MUL) or high half; out_valid rises at edge N+MUL_ITERS; FSM->IDLE. busy=1 throughout MUL.
- is_mul, func3[2]=1 (DIV/REM): single-cycle completion, out_result=0, out_illegal=1, out_reg_data_ready=0.
- out_reg_data_ready = (is_r||is_i||is_mul) && !(is_load||is_store) && !out_illegal.
- Output hold: while out_valid && !out_ready, all out_* stable. MUL completion waits internally: FSM stays in MUL, done count saturated, until the output register frees.
- out_valid clears on handshake unless a new result is loaded the same edge (back-to-back throughput 1/cycle for single-cycle ops).
- flush=1 at an edge: out_valid->0; FSM->IDLE; accumulator discarded. No accept that cycle. Flush has priority over out_ready handshake and MUL completion.
- Arithmetic wraps mod 2^XLEN; no exceptions on overflow.

Test Plan:
- ADDI src1=5, imm=0xFFFFFFFD -> result 0x00000002 one cycle after accept, out_reg_data_ready=1. SUB 3-5 -> 0xFFFFFFFE.
- SRA src1=0x80000000, src2=4 -> 0xF8000000. SRL same operands -> 0x08000000. SLTU 1<0xFFFFFFFF -> 1. SLT -> 0.
- MUL_STEP=4, MULH -2×3 -> 0xFFFFFFFF at accept+8 edges, busy=1 for 8 cycles, in_ready=0 meanwhile. MULHU 0xFFFFFFFF² -> 0xFFFFFFFE. MUL low -> 0x00000001.
- LW src1=0x1000, imm=0xFFFFFFFC -> result 0x00000FFC, out_is_load=1, out_reg_data_ready=0. DIV -> out_illegal=1, result 0.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0. Release -> handshake, next queued ADD appears next cycle.
- flush on 4th MUL cycle -> out_valid never asserts, busy=0 next cycle, in_ready=1. Async rst low mid-MUL -> all outputs 0 immediately.
